// File: rtl/spi_reg_sequencer.sv
// Register-access sequencer behind the SPI slave: decodes address/data byte pairs into
// handshaked register-bus cycles. Optional ack timeout is enabled by SPI_SEQ_TIMEOUT_EN.
module spi_reg_sequencer #(
  parameter int unsigned NUM_REGS    = 64,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_is_data,
  input  logic       i_fmt_irq,
  input  logic       i_csb_idle,
  output logic [3:0] o_xfer_len,
  output logic [7:0] o_tx_byte,
  output logic       o_enc_irq,
  output logic       o_clr_err,
  output logic [6:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_wr,
  output logic       o_reg_rd,
  input  logic [7:0] i_reg_rdata,
  input  logic       i_reg_ack,
  output logic [7:0] o_status
);

  localparam logic [6:0] StatAddr = 7'h7E;
  localparam logic [6:0] CmdAddr  = 7'h7F;

  if (NUM_REGS > 126) begin : g_bad_num_regs
    $error("NUM_REGS must not exceed 126");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_ack_timeout
    $error("ACK_TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StGotAddr, StWrReq, StRdReq} state_e;

  state_e     r_state, w_state_nxt;
  logic [6:0] r_addr, w_addr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic [7:0] r_tx_byte, w_tx_nxt;
  logic [3:0] r_status, w_status_nxt, w_set;
  logic       r_enc_irq, w_enc_nxt;
  logic       r_clr_err, w_clr_nxt;
  logic       w_clr_status, w_clr_trig, w_dec_err, w_take_addr;

  logic [6:0] w_rx_addr;
  logic       w_rx_rd, w_addr_byte, w_data_byte;
  logic       w_is_ext, w_is_stat, w_is_cmd;
  logic       w_busy, w_req, w_timeout;
  logic [7:0] w_status;

  assign w_rx_addr   = i_rx_byte[6:0];
  assign w_rx_rd     = i_rx_byte[7];
  assign w_addr_byte = i_rx_valid && !i_rx_is_data;
  assign w_data_byte = i_rx_valid && i_rx_is_data;
  assign w_is_ext    = ({25'd0, w_rx_addr} < NUM_REGS);
  assign w_is_stat   = (w_rx_addr == StatAddr);
  assign w_is_cmd    = (w_rx_addr == CmdAddr);
  assign w_busy      = (r_state != StIdle);
  assign w_req       = (r_state == StWrReq) || (r_state == StRdReq);
  assign w_status    = {3'b000, w_busy, r_status};

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [7:0] r_timer;

  assign w_timeout = w_req && !i_reg_ack && (r_timer == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timer <= 8'd0;
    end else if (w_req && !i_reg_ack && !w_timeout) begin
      r_timer <= r_timer + 8'd1;
    end else begin
      r_timer <= 8'd0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_tx_nxt     = r_tx_byte;
    w_set        = 4'b0000;
    w_clr_status = 1'b0;
    w_clr_trig   = 1'b0;
    w_dec_err    = 1'b0;
    w_take_addr  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_take_addr = w_addr_byte;
      end
      StGotAddr: begin
        if (i_fmt_irq) begin
          w_state_nxt = StIdle;
        end else if (w_data_byte) begin
          if (r_addr == CmdAddr) begin
            // Command register is handled internally; bit0 clears sticky status.
            if (i_rx_byte[0]) begin
              w_clr_status = 1'b1;
              w_clr_trig   = 1'b1;
            end
            w_state_nxt = StIdle;
          end else begin
            w_wdata_nxt = i_rx_byte;
            w_state_nxt = StWrReq;
          end
        end else begin
          w_take_addr = w_addr_byte;
        end
      end
      StWrReq: begin
        if (i_reg_ack || w_timeout) begin
          w_state_nxt = StIdle;
        end
      end
      StRdReq: begin
        if (i_reg_ack) begin
          w_tx_nxt    = i_reg_rdata;
          w_state_nxt = StIdle;
        end else if (w_timeout) begin
          w_tx_nxt    = 8'hEE;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_take_addr) begin
      if (w_rx_rd && w_is_ext) begin
        w_addr_nxt  = w_rx_addr;
        w_state_nxt = StRdReq;
      end else if (w_rx_rd && w_is_stat) begin
        w_tx_nxt    = w_status;
        w_state_nxt = StIdle;
      end else if (!w_rx_rd && (w_is_ext || w_is_cmd)) begin
        w_addr_nxt  = w_rx_addr;
        w_state_nxt = StGotAddr;
      end else begin
        w_dec_err   = 1'b1;
        w_state_nxt = StIdle;
      end
    end

    w_set[0] = i_fmt_irq;
    w_set[1] = w_dec_err;
    w_set[2] = w_req && i_rx_valid;
    w_set[3] = w_timeout;

    // Set conditions win over a simultaneous clear.
    w_status_nxt = (w_clr_status ? 4'b0000 : r_status) | w_set;

    w_enc_nxt = r_enc_irq;
    if (w_dec_err) begin
      w_enc_nxt = 1'b1;
    end else if (r_enc_irq && i_csb_idle) begin
      w_enc_nxt = 1'b0;
    end

    w_clr_nxt = r_clr_err;
    if (w_clr_trig) begin
      w_clr_nxt = 1'b1;
    end else if (r_clr_err && i_csb_idle) begin
      w_clr_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_addr    <= 7'd0;
      r_wdata   <= 8'd0;
      r_tx_byte <= 8'd0;
      r_status  <= 4'd0;
      r_enc_irq <= 1'b0;
      r_clr_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_tx_byte <= w_tx_nxt;
      r_status  <= w_status_nxt;
      r_enc_irq <= w_enc_nxt;
      r_clr_err <= w_clr_nxt;
    end
  end

  assign o_xfer_len  = 4'd8;
  assign o_tx_byte   = r_tx_byte;
  assign o_enc_irq   = r_enc_irq;
  assign o_clr_err   = r_clr_err;
  assign o_reg_addr  = r_addr;
  assign o_reg_wdata = r_wdata;
  assign o_reg_wr    = (r_state == StWrReq);
  assign o_reg_rd    = (r_state == StRdReq);
  assign o_status    = w_status;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer: a vector table of single transactions plus
// hand-written sequences for interrupt hold, fmt_irq, overrun, timeout and reset.
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_is_data;
  logic       fmt_irq;
  logic       csb_idle;
  logic [3:0] xfer_len;
  logic [7:0] tx_byte;
  logic       enc_irq;
  logic       clr_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic [7:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_reg_sequencer #(
    .NUM_REGS   (64),
    .ACK_TIMEOUT(4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_valid  (rx_valid),
    .i_rx_byte   (rx_byte),
    .i_rx_is_data(rx_is_data),
    .i_fmt_irq   (fmt_irq),
    .i_csb_idle  (csb_idle),
    .o_xfer_len  (xfer_len),
    .o_tx_byte   (tx_byte),
    .o_enc_irq   (enc_irq),
    .o_clr_err   (clr_err),
    .o_reg_addr  (reg_addr),
    .o_reg_wdata (reg_wdata),
    .o_reg_wr    (reg_wr),
    .o_reg_rd    (reg_rd),
    .i_reg_rdata (reg_rdata),
    .i_reg_ack   (reg_ack),
    .o_status    (status)
  );

  typedef struct {
    logic [7:0] a_byte;
    logic       has_data;
    logic [7:0] d_byte;
    int         ack_dly;
    logic [7:0] rdata;
    int         exp_wr;
    int         exp_rd;
    logic [6:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_tx;
    logic [7:0] exp_status;
    logic       exp_enc;
    logic       exp_clr;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    rx_is_data = 1'b0;
    fmt_irq = 1'b0;
    csb_idle = 1'b0;
    reg_ack = 1'b0;
    reg_rdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_data);
    rx_valid = 1'b1;
    rx_byte = b;
    rx_is_data = is_data;
    tick();
    rx_valid = 1'b0;
    rx_is_data = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         cnt_wr, cnt_rd;
    logic       seen;
    logic [6:0] cap_addr;
    logic [7:0] cap_wdata;
    cnt_wr = 0;
    cnt_rd = 0;
    seen = 1'b0;
    cap_addr = 7'd0;
    cap_wdata = 8'd0;
    do_reset();
    send_byte(v.a_byte, 1'b0);
    if (v.has_data) send_byte(v.d_byte, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (reg_wr || reg_rd) begin
        if (!seen) begin
          cap_addr = reg_addr;
          cap_wdata = reg_wdata;
          seen = 1'b1;
        end
        if (reg_wr) cnt_wr++;
        if (reg_rd) cnt_rd++;
        reg_ack = ((cnt_wr + cnt_rd) == v.ack_dly + 1);
        reg_rdata = v.rdata;
      end
      tick();
      reg_ack = 1'b0;
      reg_rdata = 8'h00;
    end
    if (!v.has_data) send_byte(8'h00, 1'b1);
    chk($sformatf("v%0d_wr_cycles", idx), cnt_wr, v.exp_wr);
    chk($sformatf("v%0d_rd_cycles", idx), cnt_rd, v.exp_rd);
    if (seen) begin
      chk($sformatf("v%0d_reg_addr", idx), cap_addr, v.exp_addr);
      if (cnt_wr > 0) chk($sformatf("v%0d_reg_wdata", idx), cap_wdata, v.exp_wdata);
    end
    chk($sformatf("v%0d_tx_byte", idx), tx_byte, v.exp_tx);
    chk($sformatf("v%0d_status", idx), status, v.exp_status);
    chk($sformatf("v%0d_enc_irq", idx), enc_irq, v.exp_enc);
    chk($sformatf("v%0d_clr_err", idx), clr_err, v.exp_clr);
  endtask

  initial begin
    int cnt;
    // a_byte has d_byte dly rdata wr rd addr wdata tx status enc clr
    vecs[0] = '{8'h05, 1'b1, 8'h85, 2, 8'h00, 3, 0, 7'h05, 8'h85, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'h83, 1'b0, 8'h00, 0, 8'h5A, 0, 1, 7'h03, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'h83, 1'b0, 8'h00, 3, 8'h3C, 0, 4, 7'h03, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h3F, 1'b1, 8'hA5, 0, 8'h00, 1, 0, 7'h3F, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 8'h00, 1, 8'hC3, 0, 2, 7'h00, 8'h00, 8'hC3, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h40, 1'b1, 8'h11, 0, 8'h00, 0, 0, 7'h00, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[6] = '{8'hD0, 1'b0, 8'h00, 0, 8'h00, 0, 0, 7'h00, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[7] = '{8'h7E, 1'b1, 8'h01, 0, 8'h00, 0, 0, 7'h00, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 1'b1, 8'h01, 0, 8'h00, 0, 0, 7'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};

    // Reset state
    do_reset();
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_status", status, 8'h00);
    chk("rst_reg_addr", reg_addr, 7'h00);
    chk("rst_reg_wdata", reg_wdata, 8'h00);
    chk("rst_wr_rd", {reg_wr, reg_rd}, 2'b00);
    chk("rst_irqs", {enc_irq, clr_err}, 2'b00);
    chk("xfer_len", xfer_len, 4'd8);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Decode error: enc_irq holds until the first csb_idle cycle, then status read-back
    do_reset();
    send_byte(8'hD0, 1'b0);
    chk("dec_enc_set", enc_irq, 1'b1);
    chk("dec_status", status, 8'h02);
    chk("dec_no_rd", reg_rd, 1'b0);
    tick();
    tick();
    tick();
    chk("dec_enc_hold", enc_irq, 1'b1);
    csb_idle = 1'b1;
    chk("dec_enc_idle_cycle", enc_irq, 1'b1);
    tick();
    chk("dec_enc_cleared", enc_irq, 1'b0);
    csb_idle = 1'b0;
    send_byte(8'hFE, 1'b0);
    chk("stat_rd_tx", tx_byte, 8'h02);
    chk("stat_rd_no_bus", {reg_wr, reg_rd}, 2'b00);
    send_byte(8'h00, 1'b1);

    // fmt_irq abandons GOT_ADDR, then command-register clear
    do_reset();
    send_byte(8'h05, 1'b0);
    chk("fmt_busy", status, 8'h10);
    fmt_irq = 1'b1;
    tick();
    fmt_irq = 1'b0;
    chk("fmt_status", status, 8'h01);
    send_byte(8'h77, 1'b1);
    chk("fmt_no_wr", reg_wr, 1'b0);
    send_byte(8'h7F, 1'b0);
    send_byte(8'h01, 1'b1);
    chk("clr_status", status, 8'h00);
    chk("clr_err_set", clr_err, 1'b1);
    csb_idle = 1'b1;
    chk("clr_err_idle_cycle", clr_err, 1'b1);
    tick();
    chk("clr_err_cleared", clr_err, 1'b0);
    csb_idle = 1'b0;

    // Address byte while waiting for data replaces the pending write
    do_reset();
    send_byte(8'h05, 1'b0);
    send_byte(8'h83, 1'b0);
    chk("reproc_rd", {reg_wr, reg_rd}, 2'b01);
    chk("reproc_addr", reg_addr, 7'h03);
    reg_ack = 1'b1;
    reg_rdata = 8'h6B;
    tick();
    reg_ack = 1'b0;
    chk("reproc_tx", tx_byte, 8'h6B);

    // Overrun while ack is withheld
    do_reset();
    send_byte(8'h83, 1'b0);
    tick();
    send_byte(8'h00, 1'b1);
    chk("ovr_status", status, 8'h14);
    chk("ovr_rd_held", reg_rd, 1'b1);
    chk("ovr_addr", reg_addr, 7'h03);
    reg_ack = 1'b1;
    reg_rdata = 8'h99;
    tick();
    reg_ack = 1'b0;
    chk("ovr_done_status", status, 8'h04);
    chk("ovr_rd_drop", reg_rd, 1'b0);
    chk("ovr_tx", tx_byte, 8'h99);

    // Ack timeout
    do_reset();
    send_byte(8'h81, 1'b0);
    cnt = 0;
`ifdef SPI_SEQ_TIMEOUT_EN
    for (int c = 0; c < 10; c++) begin
      if (reg_rd) cnt++;
      tick();
    end
    chk("to_rd_cycles", cnt, 4);
    chk("to_status", status, 8'h08);
    chk("to_tx", tx_byte, 8'hEE);
`else
    for (int c = 0; c < 20; c++) begin
      if (reg_rd) cnt++;
      tick();
    end
    chk("noto_rd_cycles", cnt, 20);
    chk("noto_status", status, 8'h10);
    reg_ack = 1'b1;
    reg_rdata = 8'h42;
    tick();
    reg_ack = 1'b0;
    chk("noto_done_status", status, 8'h00);
    chk("noto_tx", tx_byte, 8'h42);
`endif

    // Reset mid-request
    do_reset();
    send_byte(8'h83, 1'b0);
    send_byte(8'h00, 1'b1);
    chk("mid_pre_status", status, 8'h14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rd", reg_rd, 1'b0);
    chk("mid_rst_status", status, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
